// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types, constants and mixer FSM states.
package audio_pkg;

    localparam int SAMPLE_BITS = 16;
    // Magnitude bits of a clamped output sample.
    localparam int CLIP_LEN    = SAMPLE_BITS - 1;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        PUBLISH
    } mix_state_t;

endpackage

// File: rtl/mix_saturate.sv
// rtl/mix_saturate.sv - combinational clamp of a wide signed accumulator to OUT_W bits.
module mix_saturate #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_acc,
    output logic [OUT_W-1:0] o_sample
);

    logic [IN_W-OUT_W:0] w_hi;
    logic                w_in_range;

    // In range when every bit above the output sign bit repeats the sign.
    assign w_hi       = i_acc[IN_W-1:OUT_W-1];
    assign w_in_range = (w_hi == '0) || (w_hi == '1);

    always_comb begin
        o_sample = i_acc[OUT_W-1:0];
        if (!w_in_range) begin
            o_sample = i_acc[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/voice_mix_scheduler.sv
// rtl/voice_mix_scheduler.sv - round-robin voice collector and saturating mixer per frame tick.
// Optional MIXER_VOICE_GAIN_EN adds per-voice arithmetic right-shift gain (voice_shift).
module voice_mix_scheduler #(
    parameter int NUM_VOICES  = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic                              frame_tick,
    input  logic [NUM_VOICES-1:0]             voice_en,
    input  logic [NUM_VOICES-1:0]             voice_valid,
    input  logic [NUM_VOICES*SAMPLE_BITS-1:0] voice_sample,
`ifdef MIXER_VOICE_GAIN_EN
    input  logic [NUM_VOICES*3-1:0]           voice_shift,
`endif
    output logic [NUM_VOICES-1:0]             voice_grant,
    output logic [SAMPLE_BITS-1:0]            mix_sample,
    output logic                              mix_valid,
    output logic                              busy,
    output logic [NUM_VOICES-1:0]             underrun,
    output logic                              overrun
);
    import audio_pkg::*;

    localparam int ACC_W  = SAMPLE_BITS + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

    if (NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_bad_voices
        $error("voice_mix_scheduler: NUM_VOICES must be 1..8");
    end
    if (NUM_VOICES * (WAIT_CYCLES + 1) + 2 >= 256) begin : g_bad_latency
        $error("voice_mix_scheduler: worst-case frame latency must stay below 256 mclk");
    end

    mix_state_t                r_state, w_next;
    logic [NUM_VOICES-1:0]     r_en_q;
    logic [IDX_W-1:0]          r_idx;
    logic [WAIT_W-1:0]         r_wait;
    logic signed [ACC_W-1:0]   r_acc;
    logic [SAMPLE_BITS-1:0]    r_mix_sample;
    logic                      r_mix_valid;
    logic                      r_busy;
    logic [NUM_VOICES-1:0]     r_underrun;
    logic                      r_overrun;
    logic                      w_take, w_timeout, w_advance, w_last;
    logic signed [ACC_W-1:0]   w_contrib;
    logic [SAMPLE_BITS-1:0]    w_sat;

    assign w_take    = (r_state == SLOT) && r_en_q[r_idx] && voice_valid[r_idx];
    assign w_timeout = (r_state == SLOT) && r_en_q[r_idx] && !voice_valid[r_idx]
                       && (r_wait == WAIT_W'(WAIT_CYCLES - 1));
    assign w_advance = (r_state == SLOT) && (!r_en_q[r_idx] || voice_valid[r_idx] || w_timeout);
    assign w_last    = (r_idx == IDX_W'(NUM_VOICES - 1));

`ifdef MIXER_VOICE_GAIN_EN
    logic [NUM_VOICES*3-1:0] r_shift;
    assign w_contrib = ACC_W'($signed(voice_sample[r_idx*SAMPLE_BITS +: SAMPLE_BITS]))
                       >>> r_shift[r_idx*3 +: 3];
    always_ff @(posedge mclk) begin
        if (rst)
            r_shift <= '0;
        else if (r_state == IDLE && frame_tick)
            r_shift <= voice_shift;
    end
`else
    assign w_contrib = ACC_W'($signed(voice_sample[r_idx*SAMPLE_BITS +: SAMPLE_BITS]));
`endif

    mix_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_BITS)) u_sat (
        .i_acc    (r_acc),
        .o_sample (w_sat)
    );

    always_ff @(posedge mclk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick) w_next = SLOT;
            SLOT:    if (w_advance && w_last) w_next = PUBLISH;
            PUBLISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        voice_grant = '0;
        if (w_take)
            voice_grant[r_idx] = 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_en_q       <= '0;
            r_idx        <= '0;
            r_wait       <= '0;
            r_acc        <= '0;
            r_mix_sample <= '0;
            r_mix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_underrun   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            // Any tick outside IDLE, including the PUBLISH cycle, is dropped.
            if (frame_tick && r_state != IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: if (frame_tick) begin
                    r_en_q <= voice_en;
                    r_acc  <= '0;
                    r_idx  <= '0;
                    r_wait <= '0;
                    r_busy <= 1'b1;
                end
                SLOT: begin
                    if (w_take)
                        r_acc <= r_acc + w_contrib;
                    if (w_timeout)
                        r_underrun[r_idx] <= 1'b1;
                    if (w_advance) begin
                        r_idx  <= IDX_W'(r_idx + 1'b1);
                        r_wait <= '0;
                    end else begin
                        r_wait <= WAIT_W'(r_wait + 1'b1);
                    end
                end
                PUBLISH: begin
                    r_mix_sample <= w_sat;
                    r_mix_valid  <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mix_sample = r_mix_sample;
    assign mix_valid  = r_mix_valid;
    assign busy       = r_busy;
    assign underrun   = r_underrun;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// tb/tb_voice_mix_scheduler.sv - directed self-checking bench for voice_mix_scheduler.
module tb_voice_mix_scheduler;
    import audio_pkg::*;

    logic        mclk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [3:0]  voice_en;
    logic [3:0]  voice_valid;
    logic [63:0] voice_sample;
`ifdef MIXER_VOICE_GAIN_EN
    logic [11:0] voice_shift;
`endif
    logic [3:0]  voice_grant;
    logic [15:0] mix_sample;
    logic        mix_valid;
    logic        busy;
    logic [3:0]  underrun;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int lat, mix, nvalid, seq, bad, busy3;
    logic [3:0] en_frame;

    always #5 mclk = ~mclk;

    voice_mix_scheduler #(.NUM_VOICES(4), .SAMPLE_BITS(16), .WAIT_CYCLES(8)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .voice_en     (voice_en),
        .voice_valid  (voice_valid),
        .voice_sample (voice_sample),
`ifdef MIXER_VOICE_GAIN_EN
        .voice_shift  (voice_shift),
`endif
        .voice_grant  (voice_grant),
        .mix_sample   (mix_sample),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
        sample_t v0, v1, v2, v3;
        v0 = sample_t'(s0); v1 = sample_t'(s1); v2 = sample_t'(s2); v3 = sample_t'(s3);
        voice_sample = {v3, v2, v1, v0};
    endtask

    // Pulses one frame tick and observes a fixed 40-cycle window.
    task automatic run_frame(input int extra_k, input int en_k, input logic [3:0] en_new);
        lat = -1; mix = 0; nvalid = 0; seq = 0; bad = 0; busy3 = 0;
        en_frame = voice_en;
        @(negedge mclk) frame_tick = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge mclk);
            if (k == 1) frame_tick = 1'b0;
            if (k == extra_k) frame_tick = 1'b1;
            if (k == extra_k + 1) frame_tick = 1'b0;
            if (k == en_k) voice_en = en_new;
            if (k == 3) busy3 = int'(busy);
            if (voice_grant != 4'b0) begin
                if (!$onehot(voice_grant) || ((voice_grant & ~(voice_valid & en_frame)) != 4'b0))
                    bad = 1;
                for (int i = 0; i < 4; i++)
                    if (voice_grant[i]) seq = seq * 16 + i + 1;
            end
            if (mix_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k;
                    mix = int'($signed(mix_sample));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; voice_en = 4'hF; voice_valid = 4'hF;
        voice_sample = '0;
`ifdef MIXER_VOICE_GAIN_EN
        voice_shift = '0;
`endif
        repeat (3) @(negedge mclk);
        chk("rst_mix_sample", int'(mix_sample), 0);
        chk("rst_mix_valid", int'(mix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(voice_grant), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        @(negedge mclk);

        set_samples(1000, 2000, -500, 300);
        run_frame(0, 0, 4'h0);
        chk("basic_mix", mix, 2800);
        chk("basic_latency", lat, 6);
        chk("basic_grant_order", seq, 'h1234);
        chk("basic_nvalid", nvalid, 1);
        chk("basic_busy_mid", busy3, 1);
        chk("basic_busy_after", int'(busy), 0);
        chk("basic_grant_legal", bad, 0);

        set_samples(20000, 20000, 0, 0);
        run_frame(0, 0, 4'h0);
        chk("sat_pos", mix, 32767);

        set_samples(-20000, -20000, 0, 0);
        run_frame(0, 0, 4'h0);
        chk("sat_neg", mix, -32768);

        set_samples(1000, 2000, -500, 300);
        voice_en = 4'b0101;
        run_frame(0, 0, 4'h0);
        chk("en0101_grants", seq, 'h13);
        chk("en0101_mix", mix, 500);
        chk("en0101_legal", bad, 0);

        voice_en = 4'b0101;
        run_frame(0, 1, 4'b1010);
        chk("en_toggle_grants", seq, 'h13);
        chk("en_toggle_mix", mix, 500);

        voice_en = 4'b0000;
        run_frame(0, 0, 4'h0);
        chk("all_off_mix", mix, 0);
        chk("all_off_latency", lat, 6);
        chk("all_off_grants", seq, 0);

        voice_en = 4'hF;
        voice_valid = 4'b1011;
        set_samples(100, 200, 999, 400);
        run_frame(0, 0, 4'h0);
        chk("underrun_mix", mix, 700);
        chk("underrun_grants", seq, 'h124);
        chk("underrun_flag", int'(underrun), 4'b0100);
        chk("underrun_nvalid", nvalid, 1);

        voice_valid = 4'hF;
        set_samples(1, 2, 3, 4);
        run_frame(0, 0, 4'h0);
        chk("after_underrun_mix", mix, 10);
        chk("underrun_sticky", int'(underrun), 4'b0100);

        chk("overrun_clear_before", int'(overrun), 0);
        set_samples(1000, 2000, -500, 300);
        run_frame(2, 0, 4'h0);
        chk("overrun_flag", int'(overrun), 1);
        chk("overrun_nvalid", nvalid, 1);
        chk("overrun_mix", mix, 2800);

        voice_valid = 4'b1011;
        @(negedge mclk) frame_tick = 1'b1;
        @(negedge mclk) frame_tick = 1'b0;
        @(negedge mclk);
        @(negedge mclk) rst = 1'b1;
        @(negedge mclk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_grant", int'(voice_grant), 0);
        chk("midrst_mix_sample", int'(mix_sample), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_underrun", int'(underrun), 0);
        rst = 1'b0;
        voice_valid = 4'hF;
        @(negedge mclk);

`ifdef MIXER_VOICE_GAIN_EN
        voice_en = 4'hF;
        voice_shift = {3'd0, 3'd0, 3'd1, 3'd2};
        set_samples(8000, -8000, 0, 0);
        run_frame(0, 0, 4'h0);
        chk("gain_mix", mix, -2000);
        voice_shift = {3'd0, 3'd0, 3'd0, 3'd2};
        set_samples(8000, 0, 0, 123);
        run_frame(0, 0, 4'h0);
        chk("gain_mix_shift0", mix, 2123);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
